// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: instruction-fetch sequencer for the IM block.
//   Owns the PC register and drives the IM word address. It registers the
//   IM's combinational read data into the IF/ID stage and applies hazard
//   stalls and branch/jump redirects, with optional MIPS delay-slot
//   semantics. A fetch from an illegal address (misaligned or outside the
//   IM window) parks the block in a fault state until it is redirected.
//
// Optional feature: define IM_FETCH_CNT_EN to add the fetch_cnt output,
//   which counts valid instructions loaded into IF/ID.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   stall       in   hazard hold, freezes all state
//   redirect    in   branch/jump taken
//   redirect_pc in   redirect target byte address
//   instr_in    in   combinational IM read data for im_addr
//   im_addr     out  current PC
//   if_instr    out  IF/ID instruction register
//   if_pc       out  PC of if_instr
//   if_valid    out  if_instr holds a real instruction
//   fault       out  fetch-address fault pending
//   fault_pc    out  offending PC
//   fetch_cnt   out  valid-fetch count (IM_FETCH_CNT_EN only)
module im_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int unsigned IM_WORDS   = 4096,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] instr_in,
   output logic [31:0] im_addr,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        fault,
   output logic [31:0] fault_pc
`ifdef IM_FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   typedef enum logic {StRun, StFault} state_e;

   // Window bounds in 33 bits so RESET_PC + 4*IM_WORDS cannot wrap.
   localparam logic [32:0] LoBound = {1'b0, RESET_PC};
   localparam logic [32:0] HiBound = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic        pc_legal;
   logic        capture;

   always_comb begin
      pc_legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} >= LoBound) && ({1'b0, pc_q} < HiBound);
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      capture    = 1'b0;

      if (!stall) begin
         unique case (state_q)
            StRun: begin
               if (redirect) begin
                  pc_d = redirect_pc;
                  // Delay slot keeps the in-flight fetch; an illegal slot is
                  // dropped silently rather than faulting.
                  if (DELAY_SLOT && pc_legal) begin
                     capture = 1'b1;
                  end else begin
                     if_valid_d = 1'b0;
                     if_instr_d = '0;
                  end
               end else if (pc_legal) begin
                  capture = 1'b1;
                  pc_d    = pc_q + 32'd4;
               end else begin
                  if_valid_d = 1'b0;
                  if_instr_d = '0;
                  fault_d    = 1'b1;
                  fault_pc_d = pc_q;
                  state_d    = StFault;
               end
            end
            StFault: begin
               if (redirect) begin
                  pc_d    = redirect_pc;
                  fault_d = 1'b0;
                  state_d = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end

      if (capture) begin
         if_instr_d = instr_in;
         if_pc_d    = pc_q;
         if_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StRun;
         pc_q       <= RESET_PC;
         if_instr_q <= '0;
         if_pc_q    <= RESET_PC;
         if_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

`ifdef IM_FETCH_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (capture) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`endif

   assign im_addr  = pc_q;
   assign if_instr = if_instr_q;
   assign if_pc    = if_pc_q;
   assign if_valid = if_valid_q;
   assign fault    = fault_q;
   assign fault_pc = fault_pc_q;

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the IM block. Owns the PC register and drives the IM word address.
- Registers the IM's combinational read data into the IF/ID stage.
- Applies hazard-unit stalls and branch/jump redirects, with MIPS delay-slot semantics.
- Detects illegal fetch addresses and parks in a fault state until redirected.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; base of the IM window.
- IM_WORDS, 4096, number of 32-bit words in the IM; legal window is [RESET_PC, RESET_PC+4*IM_WORDS).
- DELAY_SLOT, 1, 1: the instruction fetched in the redirect cycle is kept (delay slot); 0: it is squashed.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit hold; freezes all state.
- redirect  input  1  branch/jump taken, resolved in D.
- redirect_pc  input  32  redirect target byte address.
- instr_in  input  32  combinational IM read data for im_addr.
- im_addr  output  32  current PC, wired to the IM PC input (combinational from the PC register).
- if_instr  output  32  IF/ID instruction register.
- if_pc  output  32  PC of if_instr.
- if_valid  output  1  if_instr holds a real instruction.
- fault  output  1  fetch-address fault pending.
- fault_pc  output  32  offending PC.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - pc=RESET_PC, state=RUN.
  - if_instr=0, if_pc=RESET_PC, if_valid=0.
  - fault=0, fault_pc=0.
  - reset overrides stall and redirect.
- legal(pc) = (pc[1:0]==0) && pc>=RESET_PC && pc<RESET_PC+4*IM_WORDS. Compare on 33-bit unsigned values so the upper bound cannot wrap.
- Latency: instruction at pc appears on if_instr one clk after pc is presented on im_addr. No read wait states.
- Priority per edge: reset > stall > redirect > sequential.
- State RUN:
  - stall=1: pc, IF/ID registers and fault outputs all hold. A redirect asserted in the same cycle is ignored; the hazard unit must re-present it.
  - Legal pc, no redirect: if_instr<=instr_in, if_pc<=pc, if_valid<=1, pc<=pc+4. pc+4 is 32-bit and wraps modulo 2^32; the wrapped value then fails legal.
  - redirect=1: pc<=redirect_pc.
    - DELAY_SLOT=1 and legal(pc): capture as in the sequential case (delay slot).
    - Otherwise: if_valid<=0, if_instr<=0.
    - No fault is raised for an illegal delay-slot address.
  - Illegal pc, no redirect: if_valid<=0, if_instr<=0, fault<=1, fault_pc<=pc, state<=FAULT. pc holds.
- State FAULT:
  - if_valid=0, fault=1, pc held, instr_in ignored.
  - stall=1 holds everything.
  - redirect=1 (no stall): pc<=redirect_pc, fault<=0, state<=RUN. The first fetch from the target occurs on the next edge.
  - fault_pc keeps its value until the next fault or reset.
- Reset asserted mid-stall or in FAULT returns to the reset values on that edge.
- The redirect target is not checked when captured; it is checked when fetched.

Optional Feature:
- Macro: IM_FETCH_CNT_EN.
- Defined:
  - Adds output port fetch_cnt (32 bits).
  - Reset value 0.
  - Increments by 1 on each edge where if_valid is loaded with 1.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Holds during stall and FAULT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then run 3 cycles with IM words 0x3000=A, 0x3004=B, 0x3008=C -> if_instr A/B/C at if_pc 3000/3004/3008, if_valid=1 from the first post-reset edge; im_addr=0x300C after 3 edges.
- stall=1 for 2 cycles at pc=0x3004 with redirect=1 and redirect_pc=0x3100 -> all outputs frozen, redirect ignored; pc resumes at 0x3004 after stall drops.
- redirect=1, redirect_pc=0x3100 at pc=0x3008:
  - DELAY_SLOT=1 -> if_pc=0x3008, if_valid=1, next if_pc=0x3100.
  - DELAY_SLOT=0 -> if_valid=0 for one cycle, then if_pc=0x3100.
- Fault cases:
  - redirect_pc=0x3002 -> after the next edge fault=1, fault_pc=0x3002, if_valid=0.
  - Out-of-range target 0x7000 faults the same way.
  - While faulted, redirect to 0x3000 -> fault=0, if_pc=0x3000 valid after 2 edges.
- Upper boundary: sequence through 0x6FFC -> valid fetch, then pc=0x7000 faults with fault_pc=0x7000.
- With IM_FETCH_CNT_EN: 5 valid fetches, 2 stall cycles, then 1 squashed slot -> fetch_cnt=5; reset -> 0.
